// File: rtl/cmp_arbiter.sv
// Shares one combinational comparator between a branch port (A) and a set/trap port (B).
// Define CMP_RR_EN for round-robin arbitration; otherwise A has fixed priority over B.
module cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic [WIDTH-1:0] a_in1,
    input  logic [WIDTH-1:0] a_in2,
    input  logic [2:0]       a_cond,
    output logic             a_gnt,
    output logic             a_done,
    output logic             a_result,
    input  logic             b_req,
    input  logic [WIDTH-1:0] b_in1,
    input  logic [WIDTH-1:0] b_in2,
    input  logic [2:0]       b_cond,
    output logic             b_gnt,
    output logic             b_done,
    output logic             b_result,
    output logic [WIDTH-1:0] cmp_in1,
    output logic [WIDTH-1:0] cmp_in2,
    output logic [WIDTH-1:0] cmp_zsrc,
    input  logic [4:0]       cmp_flags
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] op1, op2;
    logic [2:0]       op_cond;
    logic             op_id;
    logic             sample;
    logic             pick_b;
    logic             cond_true;

`ifdef CMP_RR_EN
    logic last_b;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RESP doubles as a sample point so back-to-back operations need no idle gap.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (a_req || b_req) begin
                    sample     = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
`ifdef CMP_RR_EN
        pick_b = b_req && (!a_req || !last_b);
`else
        pick_b = !a_req;
`endif
    end

    // Flags arrive as {eq, ne, lt, gt, zero}.
    always_comb begin
        cond_true = 1'b0;
        case (op_cond)
            3'd0: cond_true = cmp_flags[4];
            3'd1: cond_true = cmp_flags[3];
            3'd2: cond_true = cmp_flags[2];
            3'd3: cond_true = cmp_flags[1];
            3'd4: cond_true = cmp_flags[2] | cmp_flags[4];
            3'd5: cond_true = cmp_flags[1] | cmp_flags[4];
            3'd6: cond_true = cmp_flags[0];
            3'd7: cond_true = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op1      <= '0;
            op2      <= '0;
            op_cond  <= '0;
            op_id    <= 1'b0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            a_result <= 1'b0;
            b_result <= 1'b0;
`ifdef CMP_RR_EN
            last_b   <= 1'b1;
`endif
        end else begin
            a_gnt  <= 1'b0;
            b_gnt  <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            if (sample) begin
                op1     <= pick_b ? b_in1 : a_in1;
                op2     <= pick_b ? b_in2 : a_in2;
                op_cond <= pick_b ? b_cond : a_cond;
                op_id   <= pick_b;
                a_gnt   <= !pick_b;
                b_gnt   <= pick_b;
`ifdef CMP_RR_EN
                last_b  <= pick_b;
`endif
            end
            if (state == ISSUE) begin
                if (op_id) begin
                    b_done   <= 1'b1;
                    b_result <= cond_true;
                end else begin
                    a_done   <= 1'b1;
                    a_result <= cond_true;
                end
            end
        end
    end

    assign cmp_in1  = op1;
    assign cmp_in2  = op2;
    assign cmp_zsrc = op1;

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

- Shares the single `Xcompare` comparator between two requesters:
  - port A: branch resolution;
  - port B: set-on-condition / trap logic.
- Arbitrates, latches the winner's operands, drives the comparator and samples its 5-bit flag vector.
- Evaluates the requested condition and returns a registered one-bit result with a done pulse.
- Sits between the decode/branch stage and the comparator; the comparator stays purely combinational.

## Interface

Parameters:
- `WIDTH`, 32: operand width; must match comparator input width.

Ports:
- `clk` input 1: single clock; everything is on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `a_req` input 1: A request; held high until `a_gnt`.
- `a_in1`, `a_in2` input WIDTH: A operands; valid while `a_req` is high.
- `a_cond` input 3: A condition code.
- `a_gnt` output 1: one-cycle pulse; A request latched.
- `a_done` output 1: one-cycle pulse; `a_result` valid.
- `a_result` output 1: A condition outcome; held until the next `a_done`.
- `b_req`, `b_in1`, `b_in2`, `b_cond`, `b_gnt`, `b_done`, `b_result`: identical for B.
- `cmp_in1`, `cmp_in2` output WIDTH: drive comparator `in1`/`in2`.
- `cmp_zsrc` output WIDTH: drives comparator `alu_result`; equals latched operand 1.
- `cmp_flags` input 5: comparator output {eq, ne, lt, gt, zero}, unsigned compare.

## Operation

- Condition codes:
  - 0 EQ = eq
  - 1 NE = ne
  - 2 LT = lt
  - 3 GT = gt
  - 4 LE = lt|eq
  - 5 GE = gt|eq
  - 6 ZERO = zero (operand 1 == 0)
  - 7 ALWAYS = 1
  - All 8 codes are defined; no illegal encoding.
- FSM states:
  - IDLE: no operation in flight.
  - ISSUE: latched operands are driven onto `cmp_in1`/`cmp_in2`/`cmp_zsrc`.
  - RESP: the result is presented.
- IDLE: if any req is high, arbitrate, latch the winner's in1/in2/cond/id, then go to ISSUE; else stay in IDLE.
- ISSUE: latched operands drive the comparator. Always go to RESP; on that edge, sample `cmp_flags`, evaluate cond and register the result for the winning id.
- RESP: the winner's `done` is high. On this edge, sample requests as in IDLE: any req → ISSUE with a new winner; none → IDLE.
- The `gnt` pulse is registered: it is high in the first ISSUE cycle for the latched id.
- Requester protocol: deassert req in the cycle after seeing `gnt`, unless a new operation is ready. A req still high at the RESP sample edge counts as a new request.
- Arbitration: see Configuration. A loser keeps req high and is served at the next sample point.
- `cmp_*` outputs hold the last latched values when not in ISSUE; they are not re-zeroed.
- `x_result` changes only on that port's `done` edge. The other port's result is untouched.

## Timing

- Request sampled at edge N, then:
  - cycle N+1: ISSUE, `gnt` high;
  - edge N+2: result registered;
  - cycle N+2: RESP, `done` high.
- Latency: 2 cycles from sample edge to `done`.
- Back-to-back throughput: one operation per 2 cycles, because RESP overlaps the next sample.
- Comparator path, register → comparator → register, must close in one cycle.
- Reset (`rst_n` low at an edge):
  - state goes to IDLE;
  - `a_gnt`, `b_gnt`, `a_done`, `b_done`, `a_result`, `b_result` go to 0;
  - operand registers and `cmp_in1`, `cmp_in2`, `cmp_zsrc` go to 0;
  - the round-robin pointer goes to "B last served".
- An in-flight operation interrupted by reset is discarded and produces no `done`.
- Req inputs are ignored while `rst_n` is low.

## Configuration

- `CMP_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests, the port not served most recently wins.
  - The pointer updates on every grant.
  - After reset, A wins the first tie.
- `CMP_RR_EN` undefined: fixed priority, A always beats B.
  - B can starve under continuous A traffic.
  - No pointer register is built.

## Test plan

1. Reset, then A req with in1=5, in2=5, cond=EQ:
   - `a_gnt` high in cycle 1 after the sample edge;
   - `a_done`=1 and `a_result`=1 in cycle 2;
   - `b_done` stays 0.
2. B req with in1=3, in2=9, cond=GT → `b_result`=0. Then B req with cond=LT → `b_result`=1, with `b_done` exactly 2 cycles after the second sample edge.
3. A and B held high together for 4 operations:
   - with `CMP_RR_EN`: grants A, B, A, B;
   - without it: A, A, A, A while A stays high.
4. Back-to-back A requests with no idle gap: `a_done` pulses every 2 cycles. cond=ZERO with in1=0 → 1; with in1=1 → 0.
5. `rst_n` low during ISSUE:
   - no `done` is produced;
   - all outputs are 0 on the next cycle;
   - the next A request completes normally.
6. Sweep all 8 cond codes with in1=0xFFFFFFFF, in2=0x00000001 (unsigned):
   - required results: 0,1,0,1,0,1,0,1;
   - `a_result` holds its value between dones.
